// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB elastic pipeline register.
package pipe_pkg;

  // Default field widths of the core's MEM/WB payload.
  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int RES_SRC_W = 2;

  // Writeback mux select encodings.
  localparam logic [RES_SRC_W-1:0] RES_ALU = 2'd0;
  localparam logic [RES_SRC_W-1:0] RES_MEM = 2'd1;
  localparam logic [RES_SRC_W-1:0] RES_PC4 = 2'd2;

  // Seven-field MEM/WB payload at the core's default widths.
  typedef struct packed {
    logic [XLEN-1:0]      alu_result;
    logic [REG_AW-1:0]    rd;
    logic [XLEN-1:0]      write_data;
    logic [XLEN-1:0]      read_data;
    logic [XLEN-1:0]      pc_plus4;
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
  } mem_wb_t;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs
// one extra beat so in_ready can be a pure register (no out_ready path).
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      r_state;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & !r_skid_valid;
  assign w_out_fire = r_main_valid & out_ready;

  // Handshake FSM: moves entries between input, main and skid in FIFO order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      // Drop everything, including a beat accepted this cycle; payload holds.
      r_state      <= EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main       <= in_data;
            r_main_valid <= 1'b1;
            r_state      <= HALF;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid       <= in_data;
            r_skid_valid <= 1'b1;
            r_state      <= FULL;
          end else if (w_out_fire) begin
            r_main_valid <= 1'b0;
            r_state      <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
            r_state      <= HALF;
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_memory_elastic.sv
// MEM/WB pipeline register with valid/ready handshake, two-entry skid
// buffer, flush, and a saturating back-pressure counter.
module reg_memory_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0]   RdM,
  input  logic [DATA_WIDTH-1:0]       WriteDataM,
  input  logic [DATA_WIDTH-1:0]       ReadDataM,
  input  logic [DATA_WIDTH-1:0]       PCPlus4M,
  input  logic                        RegWriteM,
  input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       ALUResultW,
  output logic [REG_ADDR_WIDTH-1:0]   RdW,
  output logic [DATA_WIDTH-1:0]       WriteDataW,
  output logic [DATA_WIDTH-1:0]       ReadDataW,
  output logic [DATA_WIDTH-1:0]       PCPlus4W,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
  output logic [CNT_WIDTH-1:0]        stall_cycles
);

  // Same field order as mem_wb_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]       alu_result;
    logic [REG_ADDR_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0]       write_data;
    logic [DATA_WIDTH-1:0]       read_data;
    logic [DATA_WIDTH-1:0]       pc_plus4;
    logic                        reg_write;
    logic [RESULT_SRC_WIDTH-1:0] result_src;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t w_in_pl;
  payload_t w_out_pl;
  logic     w_out_valid;

  logic [CNT_WIDTH-1:0] r_stall_cnt;

  assign w_in_pl.alu_result = ALUResultM;
  assign w_in_pl.rd         = RdM;
  assign w_in_pl.write_data = WriteDataM;
  assign w_in_pl.read_data  = ReadDataM;
  assign w_in_pl.pc_plus4   = PCPlus4M;
  assign w_in_pl.reg_write  = RegWriteM;
  assign w_in_pl.result_src = ResultSrcM;

  skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pl),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pl)
  );

  assign out_valid    = w_out_valid;
  assign ALUResultW   = w_out_pl.alu_result;
  assign RdW          = w_out_pl.rd;
  assign WriteDataW   = w_out_pl.write_data;
  assign ReadDataW    = w_out_pl.read_data;
  assign PCPlus4W     = w_out_pl.pc_plus4;
  assign ResultSrcW   = w_out_pl.result_src;
  // A bubble (stale payload after flush/drain) must never write the regfile.
  assign RegWriteW    = w_out_pl.reg_write & w_out_valid;
  assign stall_cycles = r_stall_cnt;

  // Count cycles where writeback holds off a valid entry; saturate, only rst clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
